ttl_latch_bank: RTL and testbench
=================================

# ttl_latch_bank

Parametrised, clocked successor to the octal transparent latch model: a bank of `DEPTH` latches, each `WIDTH` bits wide, with an addressed write port, an addressed tri-state read port, a selectable transparent or edge-capture mode, and propagation delay modelled in whole clock cycles. It serves as the general-purpose holding-register and bus-driver primitive for the Baby datapath, covering accumulator staging and address/data bus buffering, wherever several TTL latch packages would otherwise be ganged together.

## Interface
- `WIDTH`, 8: bits per latch entry (1–32).
- `DEPTH`, 4: number of latch entries (2–16, power of two).
- `PROP_CYCLES`, 1: read-path delay in clock cycles (1–8).
- `EDGE_MODE`, 0: 0 = transparent (74x373-style), 1 = edge capture on rising `le` (74x374-style).

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `d`  in  `WIDTH`  write data.
- `wr_addr`  in  `$clog2(DEPTH)`  entry written.
- `le`  in  1  latch enable, active high.
- `rd_addr`  in  `$clog2(DEPTH)`  entry driven to `q`.
- `oe_n`  in  1  output enable, active low.
- `q`  out  `WIDTH`  data output; 3-state.
- `q_valid`  out  1  high when `q` is actively driven with entry data.

## Operation
- Storage: `mem[0..DEPTH-1]`, `WIDTH` bits each.
- Write qualifier `wr`:
  - When `EDGE_MODE=0`, `wr = le` on every cycle.
  - When `EDGE_MODE=1`, `wr = le & ~le_q`, where `le_q` is `le` registered (reset 0). The result is one capture per `le` rising edge.
- On a clock edge with `wr` set, `mem[wr_addr] <= d`. With `wr` clear, all entries hold.
- Read pipeline: `PROP_CYCLES` stages, each holding `{en, data}`.
  - Stage 0 at each edge: `en <= ~oe_n`; `data <= (wr && wr_addr==rd_addr) ? d : mem[rd_addr]` (write-through).
  - Stage n (n ≥ 1) copies stage n-1.
- Output: `q = last.en ? last.data : 'z`, and `q_valid = last.en`.
- Simultaneous write and read of the same entry returns the new `d` (transparency). A read of a different entry returns the old contents.
- When `oe_n` is high, writes still occur. Only the output floats.
- In edge mode, `le` held high writes exactly once. A new capture needs `le` to go low for at least one cycle.

## Timing
- Reset (asynchronous, immediate): all `mem` entries = 0, `le_q` = 0, all pipeline stages `{0,0}`. Result: `q` = `'z` (`'0` under bus hold), `q_valid` = 0.
- Reset mid-operation flushes in-flight reads. No stale data appears after release.
- The first edge after reset deasserts is a normal operating edge.
- Write-to-storage latency: 1 edge.
- Read latency: `PROP_CYCLES` edges from a `rd_addr`/`oe_n` change to `q`/`q_valid`.
- Write-through `d` to `q` latency: `PROP_CYCLES` edges.
- Enable and disable are symmetric. `q` goes to `'z` exactly `PROP_CYCLES` edges after `oe_n` rises.
- No combinational path from any input to `q`.

## Configuration
- `TTL_LATCH_BANK_BUS_HOLD_EN`:
  - Defined: when `last.en` = 0, `q` holds the last value driven while enabled (reset value 0). This models a bus-hold cell. `q_valid` still reads 0.
  - Undefined: a disabled output is `'z` on every bit.

## Test plan
- Reset with `WIDTH=8, DEPTH=4, PROP_CYCLES=1` → `q`=`'z`, `q_valid`=0. Then `oe_n`=0, `rd_addr`=2 → `q`=0x00 after 1 edge.
- Transparent mode: `le`=1, `wr_addr`=1, `d` = 0xA5 then 0x3C on successive cycles, `rd_addr`=1, `oe_n`=0 → `q` = 0xA5 then 0x3C. Then `le`=0 with `d`=0xFF → `q` stays 0x3C.
- Edge mode: `le` held high 3 cycles with `d` = 0x11, 0x22, 0x33 → `mem[0]`=0x11 only. Drop `le` for 1 cycle, raise it with `d`=0x44 → `mem[0]`=0x44.
- `PROP_CYCLES=3`: write 0x5A to entry 3, set `oe_n`=0 and `rd_addr`=3 → `q` becomes 0x5A on the 3rd edge. `oe_n`=1 → `q`=`'z` on the 3rd edge after (holds 0x5A with bus hold), `q_valid`=0.
- Assert `reset` asynchronously mid-read with `PROP_CYCLES=4` and entry 2 = 0x77 → `q`/`q_valid` drop immediately. After release, reading entry 2 returns 0x00.
- Simultaneous write to entry 0 (0xC3) and read of entry 0, and separately write entry 1 while reading entry 0 → the first returns 0xC3; the second returns the prior `mem[0]`.

Source files
------------

// File: rtl/ttl_latch_bank.sv
// ttl_latch_bank: a bank of DEPTH x WIDTH latches with an addressed write port
// and an addressed 3-state read port. Read delay is PROP_CYCLES clock edges.
// EDGE_MODE selects the write behaviour: 0 = transparent, 1 = capture on the
// rising edge of le.
// Optional macro TTL_LATCH_BANK_BUS_HOLD_EN: when defined, a disabled output
// holds its last driven value instead of floating.
module ttl_latch_bank #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned PROP_CYCLES = 1,
   parameter int unsigned EDGE_MODE   = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         d,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic                     le,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   input  logic                     oe_n,
   output logic [WIDTH-1:0]         q,
   output logic                     q_valid
);

   logic [WIDTH-1:0]       mem [DEPTH];
   logic                   wr;
   logic [WIDTH-1:0]       rd_data;
   logic [PROP_CYCLES-1:0] pipe_en;
   logic [WIDTH-1:0]       pipe_data [PROP_CYCLES];

   generate
      if (EDGE_MODE != 0) begin : g_edge
         logic le_q;

         // Remember le from the previous edge so that only its rising edge writes
         always_ff @(posedge clk or posedge reset) begin
            if (reset) le_q <= 1'b0;
            else       le_q <= le;
         end

         // One write per rising edge of le
         always_comb begin
            wr = le & ~le_q;
         end
      end else begin : g_level
         // Transparent mode: every cycle with le high writes
         always_comb begin
            wr = le;
         end
      end
   endgenerate

   // Read source: a same-cycle write to the read entry passes straight through
   always_comb begin
      rd_data = mem[rd_addr];
      if (wr && (wr_addr == rd_addr)) rd_data = d;
   end

   // Storage array: cleared on reset, written when the qualifier is set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr) begin
         mem[wr_addr] <= d;
      end
   end

   // Propagation pipeline: enable and data travel together through PROP_CYCLES stages
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < PROP_CYCLES; i++) begin
            pipe_en[i]   <= 1'b0;
            pipe_data[i] <= '0;
         end
      end else begin
         pipe_en[0]   <= ~oe_n;
         pipe_data[0] <= rd_data;
         for (int unsigned i = 1; i < PROP_CYCLES; i++) begin
            pipe_en[i]   <= pipe_en[i-1];
            pipe_data[i] <= pipe_data[i-1];
         end
      end
   end

   assign q_valid = pipe_en[PROP_CYCLES-1];

`ifdef TTL_LATCH_BANK_BUS_HOLD_EN
   logic [WIDTH-1:0] hold_q;

   // Bus-hold cell: remember the last value that was driven while enabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          hold_q <= '0;
      else if (pipe_en[PROP_CYCLES-1])    hold_q <= pipe_data[PROP_CYCLES-1];
   end

   assign q = pipe_en[PROP_CYCLES-1] ? pipe_data[PROP_CYCLES-1] : hold_q;
`else
   assign q = pipe_en[PROP_CYCLES-1] ? pipe_data[PROP_CYCLES-1] : 'z;
`endif

endmodule

// File: tb/tb_ttl_latch_bank.sv
// Bench for ttl_latch_bank. Three instances share one stimulus stream:
// u0 is transparent with 1-cycle delay, u1 is edge capture with 3-cycle delay,
// u2 is transparent with 4-cycle delay. A reference model tracks the expected
// storage contents and the delayed outputs for each instance.
module tb_ttl_latch_bank;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] d = '0;
   logic [1:0] wr_addr = '0;
   logic [1:0] rd_addr = '0;
   logic       le = 1'b0;
   logic       oe_n = 1'b1;

   wire [7:0] q0, q1, q2;
   wire       v0, v1, v2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ttl_latch_bank #(.WIDTH(8), .DEPTH(4), .PROP_CYCLES(1), .EDGE_MODE(0)) u0 (
      .clk(clk), .reset(reset), .d(d), .wr_addr(wr_addr), .le(le),
      .rd_addr(rd_addr), .oe_n(oe_n), .q(q0), .q_valid(v0));

   ttl_latch_bank #(.WIDTH(8), .DEPTH(4), .PROP_CYCLES(3), .EDGE_MODE(1)) u1 (
      .clk(clk), .reset(reset), .d(d), .wr_addr(wr_addr), .le(le),
      .rd_addr(rd_addr), .oe_n(oe_n), .q(q1), .q_valid(v1));

   ttl_latch_bank #(.WIDTH(8), .DEPTH(4), .PROP_CYCLES(4), .EDGE_MODE(0)) u2 (
      .clk(clk), .reset(reset), .d(d), .wr_addr(wr_addr), .le(le),
      .rd_addr(rd_addr), .oe_n(oe_n), .q(q2), .q_valid(v2));

   // Reference model state per instance
   int         pc [3] = '{1, 3, 4};
   bit         em [3] = '{1'b0, 1'b1, 1'b0};
   logic [7:0] mm [3][4];
   bit         lp [3];
   logic [7:0] held [3];
   logic [8:0] hist [3][$];   // {en,data}, newest first, length = delay

   function automatic logic [8:0] obs(int k);
      case (k)
         0:       return {v0, q0};
         1:       return {v1, q1};
         default: return {v2, q2};
      endcase
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int a = 0; a < 4; a++) mm[k][a] = 8'h00;
         lp[k]   = 1'b0;
         held[k] = 8'h00;
         hist[k].delete();
         for (int s = 0; s < pc[k]; s++) hist[k].push_back(9'h000);
      end
   endfunction

   function automatic void model_edge();
      for (int k = 0; k < 3; k++) begin
         logic [8:0] last;
         logic [7:0] rv;
         bit         w;
         last = hist[k][pc[k]-1];
         if (last[8]) held[k] = last[7:0];
         w  = em[k] ? (le && !lp[k]) : le;
         rv = (w && wr_addr == rd_addr) ? d : mm[k][rd_addr];
         hist[k].push_front({~oe_n, rv});
         void'(hist[k].pop_back());
         if (w) mm[k][wr_addr] = d;
         lp[k] = le;
      end
   endfunction

   function automatic logic [8:0] model_out(int k);
      logic [8:0] last;
      last = hist[k][pc[k]-1];
      if (last[8]) return last;
`ifdef TTL_LATCH_BANK_BUS_HOLD_EN
      return {1'b0, held[k]};
`else
      return {1'b0, 8'bzzzz_zzzz};
`endif
   endfunction

   task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed={valid,q}=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 3; k++) check($sformatf("%s.u%0d", tag, k), obs(k), model_out(k));
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   logic [8:0] dis_v;
   logic [8:0] off_5a;

   initial begin
`ifdef TTL_LATCH_BANK_BUS_HOLD_EN
      dis_v  = 9'h000;
      off_5a = 9'h05A;
`else
      dis_v  = {1'b0, 8'bzzzz_zzzz};
      off_5a = {1'b0, 8'bzzzz_zzzz};
`endif

      // Reset state
      #1 reset = 1'b1;
      model_reset();
      #1;
      check_all("reset");
      check("reset_u0", {v0, q0}, dis_v);
      #2 reset = 1'b0;

      // First read after reset
      oe_n = 1'b0; rd_addr = 2'd2;
      tick("rd_after_reset");
      check("rd_after_reset_u0", {v0, q0}, 9'h100);

      // Transparent writes with write-through
      le = 1'b1; wr_addr = 2'd1; rd_addr = 2'd1; d = 8'hA5;
      tick("transp_a5");
      check("transp_a5_u0", {v0, q0}, 9'h1A5);
      d = 8'h3C;
      tick("transp_3c");
      check("transp_3c_u0", {v0, q0}, 9'h13C);
      le = 1'b0; d = 8'hFF;
      tick("transp_hold");
      check("transp_hold_u0", {v0, q0}, 9'h13C);

      // Edge capture: le held high writes once
      le = 1'b1; wr_addr = 2'd0; d = 8'h11;
      tick("edge_11");
      d = 8'h22;
      tick("edge_22");
      d = 8'h33;
      tick("edge_33");
      le = 1'b0; rd_addr = 2'd0;
      tick("edge_rd0");
      tick("edge_rd1");
      tick("edge_rd2");
      check("edge_once_u1", {v1, q1}, 9'h111);
      le = 1'b1; d = 8'h44;
      tick("edge_44");
      le = 1'b0; d = 8'h00;
      tick("edge_44_p1");
      tick("edge_44_p2");
      check("edge_recapture_u1", {v1, q1}, 9'h144);

      // Three-cycle delay, enable then disable
      le = 1'b1; wr_addr = 2'd3; d = 8'h5A; oe_n = 1'b1;
      tick("p3_wr");
      le = 1'b0; oe_n = 1'b0; rd_addr = 2'd3;
      tick("p3_en1");
      tick("p3_en2");
      check("p3_not_yet_u1", v1, 1'b0);
      tick("p3_en3");
      check("p3_on_u1", {v1, q1}, 9'h15A);
      oe_n = 1'b1;
      tick("p3_off1");
      tick("p3_off2");
      check("p3_still_on_u1", {v1, q1}, 9'h15A);
      tick("p3_off3");
      check("p3_off_u1", {v1, q1}, off_5a);

      // Asynchronous reset in the middle of a read
      le = 1'b1; wr_addr = 2'd2; d = 8'h77;
      tick("p4_wr");
      le = 1'b0; rd_addr = 2'd2; oe_n = 1'b0;
      for (int i = 0; i < 4; i++) tick("p4_rd");
      check("p4_77_u2", {v2, q2}, 9'h177);
      tick("p4_inflight");
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_all("mid_reset");
      check("mid_reset_u2", {v2, q2}, dis_v);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) tick("post_reset");
      check("post_reset_u2", {v2, q2}, 9'h100);

      // Same-entry write/read, then write elsewhere while reading
      le = 1'b1; wr_addr = 2'd0; rd_addr = 2'd0; d = 8'hC3; oe_n = 1'b0;
      tick("wt_same");
      check("wt_same_u0", {v0, q0}, 9'h1C3);
      wr_addr = 2'd1; d = 8'h99;
      tick("wt_other");
      check("wt_other_u0", {v0, q0}, 9'h1C3);

      // Random traffic with occasional asynchronous resets
      for (int n = 0; n < 400; n++) begin
         d       = 8'($urandom);
         wr_addr = 2'($urandom);
         rd_addr = 2'($urandom);
         le      = 1'($urandom);
         oe_n    = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 63) == 0) begin
            #3 reset = 1'b1;
            model_reset();
            #1;
            check_all("rand_reset");
            #1 reset = 1'b0;
         end else begin
            tick("rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
